// File: rtl/gpu_cmd_pkg.sv
// Shared types for the GPU command decoder: opcode encoding, per-opcode
// argument counts, the assembled command bundle and the FSM state encoding.
package gpu_cmd_pkg;

   localparam int OPC_W        = 4;
   localparam int IMM_W        = 24;
   localparam int CMD_DATA_W   = 32;
   localparam int CMD_MAX_ARGS = 3;

   typedef enum logic [OPC_W-1:0] {
      OPC_NOP       = 4'd0,
      OPC_CLEAR     = 4'd1,
      OPC_SET_COLOR = 4'd2,
      OPC_PIXEL     = 4'd3,
      OPC_LINE      = 4'd4,
      OPC_TRI       = 4'd5
   } opcode_e;

   typedef enum logic [1:0] {
      ST_HDR   = 2'd0,
      ST_ARG   = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   // One fully assembled command; args[0] is the first word after the header.
   typedef struct packed {
      opcode_e                                   opcode;
      logic [IMM_W-1:0]                          imm;
      logic [1:0]                                argc;
      logic [CMD_MAX_ARGS-1:0][CMD_DATA_W-1:0]   args;
   } gpu_cmd_t;

   // Opcodes 6..15 have no defined meaning and are rejected.
   function automatic logic opc_legal(input logic [OPC_W-1:0] op);
      return (op <= 4'd5);
   endfunction

   // Number of argument words that follow a header with this opcode.
   function automatic logic [1:0] opc_argc(input logic [OPC_W-1:0] op);
      logic [1:0] n;
      case (op)
         4'd2, 4'd3: n = 2'd1;
         4'd4:       n = 2'd2;
         4'd5:       n = 2'd3;
         default:    n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/gpu_cmd_decoder.sv
// Command decoder behind the input FIFO: pops a header plus 0-3 argument
// words, holds the assembled command on a valid/ready port until accepted,
// swallows NOPs and pulses illegal_op for unknown opcodes.
// Optional build macro CMD_DECODER_STATS_EN adds cmd_count / err_count.
module gpu_cmd_decoder
   import gpu_cmd_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MAX_ARGS = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_rdata,
   output logic              fifo_read,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [3:0]        cmd_opcode,
   output logic [23:0]       cmd_imm,
   output logic [1:0]        cmd_argc,
   output logic [DATA_W-1:0] cmd_arg0,
   output logic [DATA_W-1:0] cmd_arg1,
   output logic [DATA_W-1:0] cmd_arg2,
   output logic              busy,
   output logic              illegal_op
`ifdef CMD_DECODER_STATS_EN
   ,
   output logic [15:0]       cmd_count,
   output logic [7:0]        err_count
`endif
);

   state_e     state_q, state_d;
   gpu_cmd_t   cmd_q, cmd_d;
   logic [1:0] idx_q, idx_d;
   logic       illegal_q, illegal_d;
   logic       pop;
   logic       hs;
   logic [3:0] hdr_op;

   // Pop whenever a fetch state sees a word; gated by reset so nothing is
   // consumed while the block is being cleared.
   assign pop       = !reset && !fifo_empty &&
                      ((state_q == ST_HDR) || (state_q == ST_ARG));
   assign fifo_read = pop;
   assign hs        = (state_q == ST_ISSUE) && cmd_ready;
   assign hdr_op    = fifo_rdata[31:28];

   // Next-state, argument capture and illegal-opcode detection.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      idx_d     = idx_q;
      illegal_d = 1'b0;
      case (state_q)
         ST_HDR: begin
            if (pop) begin
               if (hdr_op == 4'd0) begin
                  state_d = ST_HDR;
               end else if (!opc_legal(hdr_op)) begin
                  illegal_d = 1'b1;
               end else begin
                  cmd_d.opcode = opcode_e'(hdr_op);
                  cmd_d.imm    = fifo_rdata[23:0];
                  cmd_d.argc   = opc_argc(hdr_op);
                  cmd_d.args   = '0;
                  idx_d        = 2'd0;
                  state_d      = (opc_argc(hdr_op) == 2'd0) ? ST_ISSUE : ST_ARG;
               end
            end
         end
         ST_ARG: begin
            if (pop) begin
               if (int'(idx_q) < MAX_ARGS)
                  cmd_d.args[idx_q] = CMD_DATA_W'(fifo_rdata);
               idx_d = idx_q + 2'd1;
               if ((idx_q + 2'd1) == cmd_q.argc)
                  state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready)
               state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase
   end

   // State and command registers; reset drops any partial or pending command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_HDR;
         cmd_q     <= '0;
         idx_q     <= 2'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         idx_q     <= idx_d;
         illegal_q <= illegal_d;
      end
   end

   assign cmd_valid  = (state_q == ST_ISSUE);
   assign busy       = (state_q != ST_HDR);
   assign illegal_op = illegal_q;
   assign cmd_opcode = cmd_q.opcode;
   assign cmd_imm    = cmd_q.imm;
   assign cmd_argc   = cmd_q.argc;
   assign cmd_arg0   = DATA_W'(cmd_q.args[0]);
   assign cmd_arg1   = DATA_W'(cmd_q.args[1]);
   assign cmd_arg2   = DATA_W'(cmd_q.args[2]);

`ifdef CMD_DECODER_STATS_EN
   logic [15:0] cmd_count_q, cmd_count_d;
   logic [7:0]  err_count_q, err_count_d;

   // Free-running wrap-around counters of accepted commands and rejected headers.
   always_comb begin
      cmd_count_d = cmd_count_q + 16'(hs);
      err_count_d = err_count_q + 8'(illegal_d);
   end

   // Counter registers, cleared with the rest of the block.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_count_q <= 16'd0;
         err_count_q <= 8'd0;
      end else begin
         cmd_count_q <= cmd_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign cmd_count = cmd_count_q;
   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_gpu_cmd_decoder.sv
// Self-checking bench for gpu_cmd_decoder. The FIFO is a queue owned by the
// stimulus process; expected commands come from parsing the pushed word
// stream against the opcode table.
module tb_gpu_cmd_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        fifo_empty;
   logic [31:0] fifo_rdata;
   logic        fifo_read;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode;
   logic [23:0] cmd_imm;
   logic [1:0]  cmd_argc;
   logic [31:0] cmd_arg0, cmd_arg1, cmd_arg2;
   logic        busy;
   logic        illegal_op;
`ifdef CMD_DECODER_STATS_EN
   logic [15:0] cmd_count;
   logic [7:0]  err_count;
`endif

   gpu_cmd_decoder dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_read(fifo_read), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_imm(cmd_imm), .cmd_argc(cmd_argc),
      .cmd_arg0(cmd_arg0), .cmd_arg1(cmd_arg1), .cmd_arg2(cmd_arg2),
      .busy(busy), .illegal_op(illegal_op)
`ifdef CMD_DECODER_STATS_EN
      , .cmd_count(cmd_count), .err_count(err_count)
`endif
   );

   always #5 clk = ~clk;

   typedef logic [125:0] bundle_t;   // {opcode, imm, argc, arg0, arg1, arg2}

   int          checks = 0;
   int          errors = 0;
   logic [31:0] fq[$];
   bundle_t     exp_q[$];
   int          argc_tbl[6] = '{0, 0, 1, 1, 2, 3};
   int          pushes = 0, pops = 0, discarded = 0;
   int          exp_err = 0, ill_seen = 0, hs_seen = 0;
   logic        prev_hold = 1'b0;
   bundle_t     snap;

   function automatic bundle_t cur();
      return {cmd_opcode, cmd_imm, cmd_argc, cmd_arg0, cmd_arg1, cmd_arg2};
   endfunction

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_rdata = (fq.size() == 0) ? 32'h0 : fq[0];
   endtask

   task automatic push(input logic [31:0] w);
      fq.push_back(w);
      pushes++;
      refresh();
   endtask

   task automatic flush_fifo();
      discarded += fq.size();
      fq.delete();
      refresh();
   endtask

   // Reference: walk the stream, one header then argc words per command.
   task automatic expect_stream(input logic [31:0] w[$]);
      int i = 0;
      logic [31:0] hdr;
      logic [31:0] a[3];
      int op, n;
      while (i < w.size()) begin
         hdr = w[i];
         op  = int'(hdr[31:28]);
         if (op == 0) i++;
         else if (op > 5) begin exp_err++; i++; end
         else begin
            n = argc_tbl[op];
            a = '{32'h0, 32'h0, 32'h0};
            for (int k = 0; k < n; k++) a[k] = w[i+1+k];
            exp_q.push_back({hdr[31:28], hdr[23:0], 2'(n), a[0], a[1], a[2]});
            i += 1 + n;
         end
      end
   endtask

   // One clock: observe at the falling edge, update the FIFO just after the rising edge.
   task automatic step();
      logic fire;
      bundle_t e;
      @(negedge clk);
      fire = fifo_read;
      if (!reset) begin
         checks++;
         if (fifo_read && fifo_empty) begin
            errors++; $display("FAIL pop_when_empty: fifo_read=1 required 0");
         end
         if (cmd_valid && cmd_ready) begin
            hs_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL unexpected_cmd: got %h required none", cur());
            end else begin
               e = exp_q.pop_front();
               if (cur() !== e) begin
                  errors++; $display("FAIL cmd_bundle: got %h required %h", cur(), e);
               end
            end
         end
         if (prev_hold) begin
            checks++;
            if (!cmd_valid || cur() !== snap) begin
               errors++; $display("FAIL hold_stable: valid=%0b got %h required %h", cmd_valid, cur(), snap);
            end
         end
         if (illegal_op) ill_seen++;
      end
      prev_hold = cmd_valid && !cmd_ready && !reset;
      snap = cur();
      @(posedge clk);
      #1;
      if (fire) begin
         if (fq.size() != 0) void'(fq.pop_front());
         pops++;
      end
      refresh();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((fq.size() != 0 || busy || cmd_valid) && n < budget) begin
         step(); n++;
      end
      checks++;
      if (n >= budget) begin
         errors++; $display("FAIL idle_timeout: still busy after %0d cycles required idle", n);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL missing_cmds: %0d outstanding required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_ready = 1'b1;
      push(32'h4000_0000); push(32'h0005_000A);
      checks++;
      if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_read0: got %b required 0", fifo_read); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (fifo_read !== 1'b0 || cmd_valid !== 1'b0 || busy !== 1'b0 || illegal_op !== 1'b0 || cur() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b v=%b busy=%b ill=%b bundle=%h required all 0",
                     fifo_read, cmd_valid, busy, illegal_op, cur());
         end
`ifdef CMD_DECODER_STATS_EN
         checks++;
         if (cmd_count !== 16'd0 || err_count !== 8'd0) begin
            errors++; $display("FAIL reset_counters: %0d/%0d required 0/0", cmd_count, err_count);
         end
`endif
      end
      flush_fifo();
      reset = 1'b0;
   endtask

   task automatic test_line();
      logic [31:0] w[$] = '{32'h4000_0000, 32'h0005_000A, 32'h0064_00C8};
      int n = 0;
      cmd_ready = 1'b1;
      expect_stream(w);
      foreach (w[i]) push(w[i]);
      while (!cmd_valid && n < 10) begin step(); n++; end
      checks++;
      if (n != 3) begin errors++; $display("FAIL line_latency: valid after %0d edges required 3", n); end
      checks++;
      if (cmd_opcode !== 4'd4 || cmd_argc !== 2'd2 || cmd_arg0 !== 32'h0005_000A ||
          cmd_arg1 !== 32'h0064_00C8 || cmd_arg2 !== 32'h0) begin
         errors++; $display("FAIL line_fields: got %h", cur());
      end
      step();
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("FAIL line_valid_drop: got %b required 0", cmd_valid); end
      wait_idle(20);
   endtask

   task automatic test_ready_hold();
      logic [31:0] w[$] = '{32'h5ABC_DEF0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      bundle_t held;
      int n = 0, hs0;
      cmd_ready = 1'b0;
      expect_stream(w);
      foreach (w[i]) push(w[i]);
      while (!cmd_valid && n < 12) begin step(); n++; end
      held = cur();
      push(32'h0000_0000);
      hs0 = hs_seen;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (cmd_valid !== 1'b1 || fifo_read !== 1'b0 || cur() !== held) begin
            errors++; $display("FAIL tri_hold: v=%b rd=%b got %h required %h", cmd_valid, fifo_read, cur(), held);
         end
      end
      cmd_ready = 1'b1;
      step();
      checks++;
      if (cmd_valid !== 1'b0 || hs_seen != hs0 + 1) begin
         errors++; $display("FAIL tri_handshake: v=%b hs=%0d required v=0 hs=%0d", cmd_valid, hs_seen - hs0, 1);
      end
      wait_idle(20);
   endtask

   task automatic test_arg_stall();
      logic [31:0] w[$] = '{32'h5000_0042, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
      int p0 = pops;
      cmd_ready = 1'b1;
      expect_stream(w);
      push(w[0]); push(w[1]);
      step(); step();
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (busy !== 1'b1 || fifo_read !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL arg_stall: busy=%b rd=%b v=%b required 1/0/0", busy, fifo_read, cmd_valid);
         end
      end
      push(w[2]); push(w[3]);
      wait_idle(20);
      checks++;
      if (pops - p0 != 4) begin errors++; $display("FAIL arg_stall_pops: got %0d required 4", pops - p0); end
   endtask

   task automatic test_illegal_nop();
      logic [31:0] w[$] = '{32'hF000_0000, 32'h0000_0000, 32'h1012_3456};
      int i0 = ill_seen, e0 = exp_err;
      cmd_ready = 1'b1;
      expect_stream(w);
      foreach (w[i]) push(w[i]);
      wait_idle(20);
      checks++;
      if (ill_seen - i0 != 1 || exp_err - e0 != 1) begin
         errors++; $display("FAIL illegal_pulses: got %0d required 1", ill_seen - i0);
      end
      checks++;
      if (cmd_opcode !== 4'd1 || cmd_imm !== 24'h12_3456 || cmd_argc !== 2'd0) begin
         errors++; $display("FAIL clear_fields: op=%h imm=%h argc=%0d required 1/123456/0", cmd_opcode, cmd_imm, cmd_argc);
      end
   endtask

   task automatic test_random();
      logic [31:0] w[$];
      logic [31:0] hdr;
      int op, idx = 0, n = 0;
      for (int c = 0; c < 60; c++) begin
         op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 15);
         hdr = $urandom();
         hdr[31:28] = 4'(op);
         w.push_back(hdr);
         if (op >= 1 && op <= 5)
            for (int k = 0; k < argc_tbl[op]; k++) w.push_back($urandom());
      end
      expect_stream(w);
      while ((idx < w.size() || fq.size() != 0 || busy) && n < 4000) begin
         if (idx < w.size() && $urandom_range(0, 3) != 0) begin push(w[idx]); idx++; end
         cmd_ready = ($urandom_range(0, 2) != 0);
         step(); n++;
      end
      cmd_ready = 1'b1;
      wait_idle(50);
   endtask

   task automatic test_reset_mid();
      logic [31:0] w[$] = '{32'h5000_0001, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
      logic [31:0] w2[$] = '{32'h4077_0000, 32'hDEAD_0001, 32'hBEEF_0002};
      cmd_ready = 1'b1;
`ifdef CMD_DECODER_STATS_EN
      begin
         logic [31:0] s[$] = '{32'h1000_0001, 32'h7000_0000, 32'h2000_0002, 32'h0000_00AA,
                               32'h3000_0003, 32'h0000_00BB, 32'hC000_0000, 32'h1000_0004};
         reset = 1'b1; step(); reset = 1'b0;
         expect_stream(s);
         foreach (s[i]) push(s[i]);
         wait_idle(40);
         checks++;
         if (cmd_count !== 16'd4 || err_count !== 8'd2) begin
            errors++; $display("FAIL stats_counts: %0d/%0d required 4/2", cmd_count, err_count);
         end
      end
`endif
      expect_stream(w);
      foreach (w[i]) push(w[i]);
      step(); step();
      reset = 1'b1;
      void'(exp_q.pop_back());
      step();
      checks++;
      if (fifo_read !== 1'b0 || busy !== 1'b0 || cmd_valid !== 1'b0 || cur() !== '0) begin
         errors++; $display("FAIL mid_reset: rd=%b busy=%b v=%b bundle=%h required 0", fifo_read, busy, cmd_valid, cur());
      end
`ifdef CMD_DECODER_STATS_EN
      checks++;
      if (cmd_count !== 16'd0 || err_count !== 8'd0) begin
         errors++; $display("FAIL mid_reset_counters: %0d/%0d required 0/0", cmd_count, err_count);
      end
`endif
      flush_fifo();
      reset = 1'b0;
      expect_stream(w2);
      foreach (w2[i]) push(w2[i]);
      wait_idle(20);
      checks++;
      if (cmd_opcode !== 4'd4 || cmd_imm !== 24'h77_0000 || cmd_arg0 !== 32'hDEAD_0001 || cmd_arg1 !== 32'hBEEF_0002) begin
         errors++; $display("FAIL post_reset_cmd: got %h", cur());
      end
   endtask

   initial begin
      reset = 1'b1; cmd_ready = 1'b0;
      refresh();
      test_reset();
      test_line();
      test_ready_hold();
      test_arg_stall();
      test_illegal_nop();
      test_random();
      test_reset_mid();
      checks++;
      if (ill_seen != exp_err) begin errors++; $display("FAIL illegal_total: got %0d required %0d", ill_seen, exp_err); end
      checks++;
      if (pops != pushes - discarded) begin
         errors++; $display("FAIL pop_total: got %0d required %0d", pops, pushes - discarded);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
